// File: rtl/contrast_pkg.sv
// Shared types for the stream pattern generator: FSM states, pattern modes
// and a counter-width helper.
package contrast_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RAMP_H  = 2'd0,
        RAMP_V  = 2'd1,
        CHECKER = 2'd2,
        CONST   = 2'd3
    } mode_t;

    // Width of a counter covering 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_stream_if.sv
// Minimal AXI4-Stream bundle carrying tdata/tvalid/tready/tlast/tuser.
interface AxiStreamIf #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic                  tuser;

    modport Master (output tdata, tvalid, tlast, tuser, input tready);
    modport Slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/stream_xy_counter.sv
// Raster position counter: x runs 0..width-1 per line, y runs 0..height-1
// per frame; both wrap at their end.
module stream_xy_counter
    import contrast_pkg::*;
#(
    parameter int width  = 640,
    parameter int height = 512,
    localparam int XW    = cnt_width(width),
    localparam int YW    = cnt_width(height)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          advance,
    input  logic          clear,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          eol,
    output logic          eof
);

    assign eol = (x == XW'(width - 1));
    assign eof = eol && (y == YW'(height - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (eol) begin
                x <= '0;
                y <= eof ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_pattern_gen.sv
// Test-pattern video source: emits FRAME_WIDTH x FRAME_HEIGHT pixel frames
// over AXI4-Stream with optional idle gap after each line.
module stream_pattern_gen
    import contrast_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 512,
    parameter int GAP_CYCLES   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    AxiStreamIf.Master            m_axis,
    input  logic                  start,
    input  logic                  continuous,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] const_value,
    output logic                  busy,
    output logic                  frame_done,
    output logic [15:0]           frame_cnt
);

    localparam int XW = cnt_width(FRAME_WIDTH);
    localparam int YW = cnt_width(FRAME_HEIGHT);
    localparam int GW = cnt_width(GAP_CYCLES);

    state_t                state, state_nx;
    mode_t                 mode_q;
    logic [DATA_WIDTH-1:0] const_q;
    logic [GW-1:0]         gap_cnt;
    logic                  restart;
    logic                  latch;
    logic                  clear;
    logic                  active;
    logic                  accept;
    logic                  gap_last;
    logic [XW-1:0]         x;
    logic [YW-1:0]         y;
    logic                  eol;
    logic                  eof;
    logic                  x_b3;
    logic                  y_b3;
    logic [DATA_WIDTH-1:0] pix;
    logic                  unused_bits;

    stream_xy_counter #(
        .width  (FRAME_WIDTH),
        .height (FRAME_HEIGHT)
    ) u_xy (
        .clk     (clk),
        .rst_n   (rst_n),
        .advance (accept),
        .clear   (clear),
        .x       (x),
        .y       (y),
        .eol     (eol),
        .eof     (eof)
    );

    assign active   = (state == ACTIVE);
    assign accept   = active && m_axis.tready;
    assign gap_last = (gap_cnt == GW'(GAP_CYCLES - 1));
    assign busy     = (state != IDLE);

    always_comb begin
        state_nx = state;
        latch    = 1'b0;
        clear    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = ACTIVE;
                    latch    = 1'b1;
                    clear    = 1'b1;
                end
            end
            ACTIVE: begin
                if (accept && eol) begin
                    if (eof && !continuous) begin
                        state_nx = IDLE;
                    end else if (GAP_CYCLES > 0) begin
                        state_nx = GAP;
                    end else begin
                        latch = eof;
                    end
                end
            end
            GAP: begin
                if (gap_last) begin
                    state_nx = ACTIVE;
                    latch    = restart;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gap_cnt    <= '0;
            restart    <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            state      <= state_nx;
            frame_done <= accept && eof;
            if (accept && eof) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            // restart marks a gap that follows a frame end rather than a line end
            if (accept && eol) begin
                restart <= eof && continuous;
            end
            if (state == GAP) begin
                gap_cnt <= gap_last ? '0 : gap_cnt + 1'b1;
            end else begin
                gap_cnt <= '0;
            end
        end
    end

    // Pattern settings are frozen for the whole frame once latched.
    always_ff @(posedge clk) begin
        if (latch) begin
            mode_q  <= mode_t'(mode);
            const_q <= const_value;
        end
    end

    if (XW > 3) begin : g_xb3
        assign x_b3 = x[3];
    end else begin : g_xb3_zero
        assign x_b3 = 1'b0;
    end

    if (YW > 3) begin : g_yb3
        assign y_b3 = y[3];
    end else begin : g_yb3_zero
        assign y_b3 = 1'b0;
    end

    assign unused_bits = ^{x, y};

    always_comb begin
        pix = '0;
        case (mode_q)
            RAMP_H:  pix = DATA_WIDTH'(x);
            RAMP_V:  pix = DATA_WIDTH'(y);
            CHECKER: pix = (x_b3 ^ y_b3) ? '1 : '0;
            CONST:   pix = const_q;
            default: pix = '0;
        endcase
    end

    assign m_axis.tvalid = active;
    assign m_axis.tdata  = active ? pix : '0;
    assign m_axis.tlast  = active && eol;
    assign m_axis.tuser  = active && (x == '0) && (y == '0);

endmodule

// File: tb/tb_stream_pattern_gen.sv
// Bench for stream_pattern_gen: three instances (4x2 gap 2, 16x2 gap 2,
// 4x2 no gap) traced every cycle and compared with a raster-order model.
module tb_stream_pattern_gen;

    typedef struct {
        logic        v;
        logic        r;
        logic        l;
        logic        u;
        logic        fd;
        logic        busy;
        logic [7:0]  d;
        logic [15:0] cnt;
    } smp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        continuous;
    logic [1:0]  mode;
    logic [7:0]  const_value;
    logic        rdy;
    logic        busy_a, fd_a, busy_b, fd_b, busy_c, fd_c;
    logic [15:0] cnt_a, cnt_b, cnt_c;
    logic        cap_en = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    smp_t tr_a[$];
    smp_t tr_b[$];
    smp_t tr_c[$];
    smp_t cur[$];
    smp_t bt[$];
    int   bt_at[$];

    always #5 clk = ~clk;

    AxiStreamIf #(.DATA_WIDTH(8)) ax_a ();
    AxiStreamIf #(.DATA_WIDTH(8)) ax_b ();
    AxiStreamIf #(.DATA_WIDTH(8)) ax_c ();

    assign ax_a.tready = rdy;
    assign ax_b.tready = rdy;
    assign ax_c.tready = rdy;

    stream_pattern_gen #(.DATA_WIDTH(8), .FRAME_WIDTH(4), .FRAME_HEIGHT(2), .GAP_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .m_axis(ax_a), .start(start), .continuous(continuous),
        .mode(mode), .const_value(const_value), .busy(busy_a), .frame_done(fd_a), .frame_cnt(cnt_a));

    stream_pattern_gen #(.DATA_WIDTH(8), .FRAME_WIDTH(16), .FRAME_HEIGHT(2), .GAP_CYCLES(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .m_axis(ax_b), .start(start), .continuous(continuous),
        .mode(mode), .const_value(const_value), .busy(busy_b), .frame_done(fd_b), .frame_cnt(cnt_b));

    stream_pattern_gen #(.DATA_WIDTH(8), .FRAME_WIDTH(4), .FRAME_HEIGHT(2), .GAP_CYCLES(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .m_axis(ax_c), .start(start), .continuous(continuous),
        .mode(mode), .const_value(const_value), .busy(busy_c), .frame_done(fd_c), .frame_cnt(cnt_c));

    always @(negedge clk) begin
        #2;
        if (cap_en) begin
            tr_a.push_back('{ax_a.tvalid, ax_a.tready, ax_a.tlast, ax_a.tuser, fd_a, busy_a, ax_a.tdata, cnt_a});
            tr_b.push_back('{ax_b.tvalid, ax_b.tready, ax_b.tlast, ax_b.tuser, fd_b, busy_b, ax_b.tdata, cnt_b});
            tr_c.push_back('{ax_c.tvalid, ax_c.tready, ax_c.tlast, ax_c.tuser, fd_c, busy_c, ax_c.tdata, cnt_c});
        end
    end

    function automatic logic [7:0] exp_pix(input int m, input int x, input int y, input logic [7:0] c);
        case (m)
            0:       return 8'(x % 256);
            1:       return 8'(y % 256);
            2:       return (((x / 8) % 2) != ((y / 8) % 2)) ? 8'hFF : 8'h00;
            default: return c;
        endcase
    endfunction

    function automatic int idle_after(input int idx);
        int n = 0;
        for (int j = idx + 1; j < cur.size() && !cur[j].v; j++) n++;
        return n;
    endfunction

    function automatic int fd_pulses();
        int n = 0;
        foreach (cur[i]) if (cur[i].fd) n++;
        return n;
    endfunction

    task automatic extract(input int which);
        cur.delete();
        bt.delete();
        bt_at.delete();
        case (which)
            0:       cur = tr_a;
            1:       cur = tr_b;
            default: cur = tr_c;
        endcase
        foreach (cur[i]) begin
            if (cur[i].v && cur[i].r) begin
                bt.push_back(cur[i]);
                bt_at.push_back(i);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        cap_en = 1'b0;
        rst_n = 1'b0;
        start = 1'b0;
        continuous = 1'b0;
        mode = 2'd0;
        const_value = 8'h00;
        rdy = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tr_a.delete();
        tr_b.delete();
        tr_c.delete();
    endtask

    task automatic end_capture();
        @(negedge clk);
        cap_en = 1'b0;
        #3;
    endtask

    task automatic test_reset();
        int vcount = 0;
        @(negedge clk);
        rst_n = 1'b0; start = 1'b0; continuous = 1'b0; mode = 2'd0; const_value = 8'h00; rdy = 1'b1;
        #1;
        n_checks++;
        if ({ax_a.tvalid, ax_a.tdata, ax_a.tlast, ax_a.tuser, busy_a, fd_a, cnt_a} !== 29'd0) begin
            n_fail++; $display("FAIL reset_a outputs=%h required 0", {ax_a.tvalid, ax_a.tdata, ax_a.tlast, ax_a.tuser, busy_a, fd_a, cnt_a});
        end
        n_checks++;
        if ({ax_b.tvalid, ax_b.tdata, ax_b.tlast, ax_b.tuser, busy_b, fd_b, cnt_b} !== 29'd0) begin
            n_fail++; $display("FAIL reset_b outputs=%h required 0", {ax_b.tvalid, ax_b.tdata, ax_b.tlast, ax_b.tuser, busy_b, fd_b, cnt_b});
        end
        n_checks++;
        if ({ax_c.tvalid, ax_c.tdata, ax_c.tlast, ax_c.tuser, busy_c, fd_c, cnt_c} !== 29'd0) begin
            n_fail++; $display("FAIL reset_c outputs=%h required 0", {ax_c.tvalid, ax_c.tdata, ax_c.tlast, ax_c.tuser, busy_c, fd_c, cnt_c});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            if (ax_a.tvalid || ax_b.tvalid || ax_c.tvalid) vcount++;
        end
        n_checks++;
        if (vcount !== 0) begin
            n_fail++; $display("FAIL reset_idle tvalid cycles=%0d required 0", vcount);
        end
    endtask

    task automatic test_ramp_h();
        int gap;
        do_reset();
        @(negedge clk);
        cap_en = 1'b1; mode = 2'd0; start = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        end_capture();
        extract(0);
        n_checks++;
        if (cur[0].v !== 1'b0 || cur[1].v !== 1'b1) begin
            n_fail++; $display("FAIL ramp_first_valid got %b%b required 01", cur[0].v, cur[1].v);
        end
        n_checks++;
        if (bt.size() !== 8) begin
            n_fail++; $display("FAIL ramp_beat_count got %0d required 8", bt.size());
        end
        for (int i = 0; i < bt.size() && i < 8; i++) begin
            n_checks++;
            if ({bt[i].d, bt[i].u, bt[i].l} !== {exp_pix(0, i % 4, i / 4, 8'h00), (i == 0), (i % 4 == 3)}) begin
                n_fail++; $display("FAIL ramp_beat%0d data/user/last got %h/%b/%b required %h/%b/%b", i, bt[i].d, bt[i].u, bt[i].l,
                                   exp_pix(0, i % 4, i / 4, 8'h00), (i == 0), (i % 4 == 3));
            end
        end
        if (bt.size() >= 8) begin
            gap = idle_after(bt_at[3]);
            n_checks++;
            if (gap !== 2) begin
                n_fail++; $display("FAIL ramp_gap got %0d required 2", gap);
            end
            n_checks++;
            if (cur[bt_at[7] + 1].fd !== 1'b1) begin
                n_fail++; $display("FAIL ramp_frame_done_timing got %b required 1", cur[bt_at[7] + 1].fd);
            end
        end
        n_checks++;
        if (fd_pulses() !== 1) begin
            n_fail++; $display("FAIL ramp_frame_done_count got %0d required 1", fd_pulses());
        end
        n_checks++;
        if ({cur[cur.size() - 1].cnt, cur[cur.size() - 1].busy} !== {16'd1, 1'b0}) begin
            n_fail++; $display("FAIL ramp_end_state cnt=%0d busy=%b required cnt=1 busy=0", cur[cur.size() - 1].cnt, cur[cur.size() - 1].busy);
        end
    endtask

    task automatic test_const_stall();
        bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int stalls = 0;
        do_reset();
        @(negedge clk);
        cap_en = 1'b1; mode = 2'd3; const_value = 8'hA5; start = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            start = 1'b0;
            rdy = pat[k % 4];
            if (k == 3) begin
                mode = 2'd0;
                const_value = 8'h3C;
            end
        end
        end_capture();
        extract(0);
        n_checks++;
        if (bt.size() !== 8) begin
            n_fail++; $display("FAIL const_beat_count got %0d required 8", bt.size());
        end
        foreach (bt[i]) begin
            n_checks++;
            if (bt[i].d !== 8'hA5) begin
                n_fail++; $display("FAIL const_beat%0d got %h required a5", i, bt[i].d);
            end
        end
        for (int i = 0; i + 1 < cur.size(); i++) begin
            if (cur[i].v && !cur[i].r) begin
                stalls++;
                n_checks++;
                if ({cur[i + 1].v, cur[i + 1].d, cur[i + 1].l, cur[i + 1].u} !== {1'b1, cur[i].d, cur[i].l, cur[i].u}) begin
                    n_fail++; $display("FAIL const_stall_hold cycle %0d got v=%b d=%h required v=1 d=%h", i + 1, cur[i + 1].v, cur[i + 1].d, cur[i].d);
                end
            end
        end
        n_checks++;
        if (stalls < 4 || cur[cur.size() - 1].cnt !== 16'd1) begin
            n_fail++; $display("FAIL const_end stalls=%0d cnt=%0d required stalls>=4 cnt=1", stalls, cur[cur.size() - 1].cnt);
        end
    endtask

    task automatic test_continuous();
        int seen = 0;
        int nfd = 0;
        int f, p, m;
        do_reset();
        @(negedge clk);
        cap_en = 1'b1; mode = 2'd1; continuous = 1'b1; start = 1'b1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (fd_a) seen++;
            if (seen >= 2) continuous = 1'b0;
            if (k == 4) mode = 2'd0;
            rdy = ($urandom_range(0, 3) != 0);
            if (seen >= 3 && !busy_a) break;
        end
        end_capture();
        extract(0);
        n_checks++;
        if (seen < 3 || bt.size() !== 24) begin
            n_fail++; $display("FAIL cont_progress frames=%0d beats=%0d required 3 and 24", seen, bt.size());
        end
        for (int i = 0; i < bt.size() && i < 24; i++) begin
            f = i / 8;
            p = i % 8;
            m = (f == 0) ? 1 : 0;
            n_checks++;
            if ({bt[i].d, bt[i].u, bt[i].l} !== {exp_pix(m, p % 4, p / 4, 8'h00), (p == 0), (p % 4 == 3)}) begin
                n_fail++; $display("FAIL cont_beat%0d data/user/last got %h/%b/%b required %h/%b/%b", i, bt[i].d, bt[i].u, bt[i].l,
                                   exp_pix(m, p % 4, p / 4, 8'h00), (p == 0), (p % 4 == 3));
            end
            if (bt[i].l && i < 23) begin
                n_checks++;
                if (idle_after(bt_at[i]) !== 2) begin
                    n_fail++; $display("FAIL cont_gap after beat %0d got %0d required 2", i, idle_after(bt_at[i]));
                end
            end
        end
        foreach (cur[i]) begin
            if (cur[i].fd) begin
                nfd++;
                n_checks++;
                if (cur[i].cnt !== 16'(nfd)) begin
                    n_fail++; $display("FAIL cont_frame_cnt pulse %0d got %0d required %0d", nfd, cur[i].cnt, nfd);
                end
            end
        end
        n_checks++;
        if (nfd !== 3 || cur[cur.size() - 1].busy !== 1'b0) begin
            n_fail++; $display("FAIL cont_end pulses=%0d busy=%b required 3 and 0", nfd, cur[cur.size() - 1].busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        int nacc = 0;
        int vcount = 0;
        do_reset();
        @(negedge clk);
        mode = 2'd0; start = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (nacc == 3) break;
            if (ax_a.tvalid && ax_a.tready) nacc++;
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (nacc !== 3 || {ax_a.tvalid, ax_a.tdata, ax_a.tlast, ax_a.tuser, busy_a, fd_a, cnt_a} !== 29'd0) begin
            n_fail++; $display("FAIL midreset_outputs beats=%0d outputs=%h required 3 and 0", nacc, {ax_a.tvalid, ax_a.tdata, ax_a.tlast, ax_a.tuser, busy_a, fd_a, cnt_a});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            if (ax_a.tvalid || busy_a) vcount++;
        end
        n_checks++;
        if (vcount !== 0) begin
            n_fail++; $display("FAIL midreset_silent active cycles=%0d required 0", vcount);
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        n_checks++;
        if ({ax_a.tvalid, ax_a.tuser, ax_a.tdata} !== {1'b1, 1'b1, 8'h00}) begin
            n_fail++; $display("FAIL midreset_restart v/u/d got %b/%b/%h required 1/1/00", ax_a.tvalid, ax_a.tuser, ax_a.tdata);
        end
    endtask

    task automatic test_checker();
        do_reset();
        @(negedge clk);
        cap_en = 1'b1; mode = 2'd2; start = 1'b1;
        for (int k = 1; k <= 220; k++) begin
            @(negedge clk);
            start = (k == 5 || k == 20);
            if (start) mode = 2'd3;
            rdy = ($urandom_range(0, 3) != 0);
        end
        end_capture();
        extract(1);
        n_checks++;
        if (bt.size() !== 32) begin
            n_fail++; $display("FAIL checker_beat_count got %0d required 32", bt.size());
        end
        for (int i = 0; i < bt.size() && i < 32; i++) begin
            n_checks++;
            if ({bt[i].d, bt[i].u, bt[i].l} !== {exp_pix(2, i % 16, i / 16, 8'h00), (i == 0), (i % 16 == 15)}) begin
                n_fail++; $display("FAIL checker_beat%0d data/user/last got %h/%b/%b required %h/%b/%b", i, bt[i].d, bt[i].u, bt[i].l,
                                   exp_pix(2, i % 16, i / 16, 8'h00), (i == 0), (i % 16 == 15));
            end
        end
        n_checks++;
        if (cur[cur.size() - 1].cnt !== 16'd1) begin
            n_fail++; $display("FAIL checker_frame_cnt got %0d required 1", cur[cur.size() - 1].cnt);
        end
    endtask

    task automatic test_no_gap();
        do_reset();
        @(negedge clk);
        cap_en = 1'b1; mode = 2'd0; start = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        end_capture();
        extract(2);
        n_checks++;
        if (bt.size() !== 8) begin
            n_fail++; $display("FAIL nogap_beat_count got %0d required 8", bt.size());
        end
        if (bt.size() >= 8) begin
            n_checks++;
            if (bt_at[4] !== bt_at[3] + 1) begin
                n_fail++; $display("FAIL nogap_line_turn second line at %0d required %0d", bt_at[4], bt_at[3] + 1);
            end
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if ({bt[i].d, bt[i].l} !== {exp_pix(0, i % 4, i / 4, 8'h00), (i % 4 == 3)}) begin
                    n_fail++; $display("FAIL nogap_beat%0d data/last got %h/%b required %h/%b", i, bt[i].d, bt[i].l, exp_pix(0, i % 4, i / 4, 8'h00), (i % 4 == 3));
                end
            end
            n_checks++;
            if ({cur[bt_at[7] + 1].fd, cur[bt_at[7] + 1].cnt} !== {1'b1, 16'd1}) begin
                n_fail++; $display("FAIL nogap_frame_done fd=%b cnt=%0d required 1 and 1", cur[bt_at[7] + 1].fd, cur[bt_at[7] + 1].cnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        @(negedge clk);
        cap_en = 1'b1; mode = 2'd0; start = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            start = (k == 10 || k == 12);
        end
        end_capture();
        extract(0);
        n_checks++;
        if ({cur[10].v, cur[10].l, cur[11].busy, cur[12].v} !== 4'b1100) begin
            n_fail++; $display("FAIL b2b_final_beat v/l/busy/v got %b%b%b%b required 1100", cur[10].v, cur[10].l, cur[11].busy, cur[12].v);
        end
        n_checks++;
        if ({cur[13].v, cur[13].u, cur[13].d} !== {1'b1, 1'b1, 8'h00}) begin
            n_fail++; $display("FAIL b2b_restart v/u/d got %b/%b/%h required 1/1/00", cur[13].v, cur[13].u, cur[13].d);
        end
        n_checks++;
        if (bt.size() !== 16 || cur[cur.size() - 1].cnt !== 16'd2) begin
            n_fail++; $display("FAIL b2b_totals beats=%0d cnt=%0d required 16 and 2", bt.size(), cur[cur.size() - 1].cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; start = 1'b0; continuous = 1'b0; mode = 2'd0; const_value = 8'h00; rdy = 1'b1;
        test_reset();
        test_ramp_h();
        test_const_stall();
        test_continuous();
        test_reset_mid_frame();
        test_checker();
        test_no_gap();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
